// File: rtl/controle_fechadura.sv
// Lock controller for the digital-lock datapath.
//
// Consumes the PIN packet from the keypad PIN-assembly stage and compares it
// against the stored user PIN and a fixed admin PIN. Sequences unlock,
// failed-attempt counting, lockout and user-PIN reprogramming.
//
// Ports:
//   clk        - system clock, all logic on posedge
//   rst        - asynchronous, active-high reset
//   pin_in     - PIN packet {status, digit1..digit4}; digit1 oldest; 4'hA = blank
//   lock_open  - actuator drive, high only in UNLOCKED
//   blocked    - high only in BLOCKED
//   setup_mode - high only in SETUP
//   tries_left - remaining attempts before lockout
//   pin_ok     - 1-cycle pulse: user PIN accepted
//   pin_err    - 1-cycle pulse: submission rejected
//   setup_done - 1-cycle pulse: new user PIN stored

package controle_fechadura_pkg;
  typedef struct packed {
    logic       status;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] digit4;
  } pinPac_t;
endpackage

module controle_fechadura
  import controle_fechadura_pkg::*;
#(
  parameter logic [15:0] DEFAULT_PIN    = 16'h1234,
  parameter logic [15:0] ADMIN_PIN      = 16'h9999,
  parameter int          MAX_TRIES      = 3,
  parameter int          UNLOCK_CYCLES  = 5000,
  parameter int          LOCKOUT_CYCLES = 20000,
  parameter int          SETUP_CYCLES   = 20000,
  localparam int         TRW            = $clog2(MAX_TRIES + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  pinPac_t        pin_in,
  output logic           lock_open,
  output logic           blocked,
  output logic           setup_mode,
  output logic [TRW-1:0] tries_left,
  output logic           pin_ok,
  output logic           pin_err,
  output logic           setup_done
);

  // Timer only ever holds N-1 of the longest timed state.
  localparam int TMAX_A = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TMAX   = (TMAX_A > SETUP_CYCLES) ? TMAX_A : SETUP_CYCLES;
  localparam int TW     = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0]  T_UNLOCK  = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0]  T_LOCKOUT = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0]  T_SETUP   = TW'(SETUP_CYCLES - 1);
  localparam logic [TRW-1:0] TRIES_MAX = TRW'(MAX_TRIES);

  typedef enum logic [1:0] {
    S_LOCKED   = 2'd0,
    S_UNLOCKED = 2'd1,
    S_BLOCKED  = 2'd2,
    S_SETUP    = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [TRW-1:0] tries_q, tries_d;
  logic [15:0]    user_pin_q, user_pin_d;
  logic           status_q;
  logic           lock_open_q, lock_open_d;
  logic           blocked_q, blocked_d;
  logic           setup_mode_q, setup_mode_d;
  logic           pin_ok_q, pin_ok_d;
  logic           pin_err_q, pin_err_d;
  logic           setup_done_q, setup_done_d;

  logic        sub;
  logic [15:0] p;
  logic        incomplete;

  // A held status line submits only once: act on its rising edge.
  assign sub        = pin_in.status & ~status_q;
  assign p          = {pin_in.digit1, pin_in.digit2, pin_in.digit3, pin_in.digit4};
  assign incomplete = (pin_in.digit1 == 4'hA) | (pin_in.digit2 == 4'hA) |
                      (pin_in.digit3 == 4'hA) | (pin_in.digit4 == 4'hA);

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    tries_d      = tries_q;
    user_pin_d   = user_pin_q;
    pin_ok_d     = 1'b0;
    pin_err_d    = 1'b0;
    setup_done_d = 1'b0;

    case (state_q)
      S_LOCKED: begin
        if (sub) begin
          // Admin match is checked first so the admin PIN never unlocks.
          if (p == ADMIN_PIN) begin
            state_d = S_SETUP;
            timer_d = T_SETUP;
            tries_d = TRIES_MAX;
          end else if (!incomplete && (p == user_pin_q)) begin
            state_d  = S_UNLOCKED;
            timer_d  = T_UNLOCK;
            tries_d  = TRIES_MAX;
            pin_ok_d = 1'b1;
          end else begin
            pin_err_d = 1'b1;
            if (tries_q <= TRW'(1)) begin
              tries_d = '0;
              state_d = S_BLOCKED;
              timer_d = T_LOCKOUT;
            end else begin
              tries_d = tries_q - TRW'(1);
            end
          end
        end
      end

      S_UNLOCKED: begin
        if (timer_q == '0) state_d = S_LOCKED;
        else               timer_d = timer_q - TW'(1);
      end

      S_BLOCKED: begin
        if (timer_q == '0) begin
          state_d = S_LOCKED;
          tries_d = TRIES_MAX;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      S_SETUP: begin
        // Expiry wins over a coinciding submission; that submission is dropped.
        if (timer_q == '0) begin
          state_d = S_LOCKED;
        end else if (sub) begin
          state_d = S_LOCKED;
          timer_d = '0;
          if (!incomplete && (p != ADMIN_PIN)) begin
            user_pin_d   = p;
            setup_done_d = 1'b1;
          end else begin
            pin_err_d = 1'b1;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      default: begin
        state_d = S_LOCKED;
        timer_d = '0;
        tries_d = TRIES_MAX;
      end
    endcase

    lock_open_d  = (state_d == S_UNLOCKED);
    blocked_d    = (state_d == S_BLOCKED);
    setup_mode_d = (state_d == S_SETUP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_LOCKED;
      timer_q      <= '0;
      tries_q      <= TRIES_MAX;
      user_pin_q   <= DEFAULT_PIN;
      status_q     <= 1'b0;
      lock_open_q  <= 1'b0;
      blocked_q    <= 1'b0;
      setup_mode_q <= 1'b0;
      pin_ok_q     <= 1'b0;
      pin_err_q    <= 1'b0;
      setup_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      tries_q      <= tries_d;
      user_pin_q   <= user_pin_d;
      status_q     <= pin_in.status;
      lock_open_q  <= lock_open_d;
      blocked_q    <= blocked_d;
      setup_mode_q <= setup_mode_d;
      pin_ok_q     <= pin_ok_d;
      pin_err_q    <= pin_err_d;
      setup_done_q <= setup_done_d;
    end
  end

  assign lock_open  = lock_open_q;
  assign blocked    = blocked_q;
  assign setup_mode = setup_mode_q;
  assign tries_left = tries_q;
  assign pin_ok     = pin_ok_q;
  assign pin_err    = pin_err_q;
  assign setup_done = setup_done_q;

endmodule

// File: tb/tb_controle_fechadura.sv
// Directed vector bench for controle_fechadura. Each table row drives inputs
// for 'rep' cycles and checks the registered outputs just after every edge.
module tb_controle_fechadura;
  import controle_fechadura_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  pinPac_t    pin_in = '0;
  logic       lock_open, blocked, setup_mode, pin_ok, pin_err, setup_done;
  logic [1:0] tries_left;

  controle_fechadura #(
    .DEFAULT_PIN   (16'h1234),
    .ADMIN_PIN     (16'h9999),
    .MAX_TRIES     (3),
    .UNLOCK_CYCLES (8),
    .LOCKOUT_CYCLES(16),
    .SETUP_CYCLES  (12)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pin_in    (pin_in),
    .lock_open (lock_open),
    .blocked   (blocked),
    .setup_mode(setup_mode),
    .tries_left(tries_left),
    .pin_ok    (pin_ok),
    .pin_err   (pin_err),
    .setup_done(setup_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       lo, bl, su;
    logic [1:0] tl;
    logic       ok, er, dn;
  } out_t;

  typedef struct {
    int          rep;
    logic        rs;
    logic        st;
    logic [15:0] pin;
    out_t        exp;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic out_t O(bit lo, bit bl, bit su, int tl, bit ok, bit er, bit dn);
    out_t o;
    o.lo = lo; o.bl = bl; o.su = su; o.tl = 2'(tl);
    o.ok = ok; o.er = er; o.dn = dn;
    return o;
  endfunction

  function automatic vec_t V(int rep, bit rs, bit st, logic [15:0] pin, out_t exp);
    vec_t v;
    v.rep = rep; v.rs = rs; v.st = st; v.pin = pin; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input out_t exp);
    out_t act;
    act = {lock_open, blocked, setup_mode, tries_left, pin_ok, pin_err, setup_done};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got lo=%b bl=%b su=%b tl=%0d ok=%b er=%b dn=%b, want lo=%b bl=%b su=%b tl=%0d ok=%b er=%b dn=%b",
               name, act.lo, act.bl, act.su, act.tl, act.ok, act.er, act.dn,
               exp.lo, exp.bl, exp.su, exp.tl, exp.ok, exp.er, exp.dn);
    end
  endtask

  // Inputs change 1 time unit after an edge, outputs are checked at that point.
  task automatic run_tbl(input string tag);
    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].rep; r++) begin
        rst    = tbl[i].rs;
        pin_in = {tbl[i].st, tbl[i].pin};
        @(posedge clk);
        #1;
        chk($sformatf("%s row %0d cyc %0d", tag, i, r), tbl[i].exp);
      end
    end
    tbl.delete();
  endtask

  initial begin
    // Reset before any clock edge: outputs must come from the async path.
    #1 rst = 1'b1;
    #2 chk("reset async", O(0,0,0,3,0,0,0));
    @(posedge clk); #1;
    chk("reset held", O(0,0,0,3,0,0,0));
    rst = 1'b0;

    // Unlock; second submission while open is ignored.
    tbl.push_back(V(1,0,1,16'h1234,O(1,0,0,3,1,0,0)));
    tbl.push_back(V(1,0,0,16'h1234,O(1,0,0,3,0,0,0)));
    tbl.push_back(V(1,0,1,16'h1234,O(1,0,0,3,0,0,0)));
    tbl.push_back(V(5,0,0,16'h1234,O(1,0,0,3,0,0,0)));
    tbl.push_back(V(1,0,0,16'h0000,O(0,0,0,3,0,0,0)));
    // Three failures -> lockout for 16 cycles; submission while blocked ignored.
    tbl.push_back(V(1,0,1,16'h1111,O(0,0,0,2,0,1,0)));
    tbl.push_back(V(1,0,0,16'h1111,O(0,0,0,2,0,0,0)));
    tbl.push_back(V(1,0,1,16'h1111,O(0,0,0,1,0,1,0)));
    tbl.push_back(V(1,0,0,16'h1111,O(0,0,0,1,0,0,0)));
    tbl.push_back(V(1,0,1,16'h1111,O(0,1,0,0,0,1,0)));
    tbl.push_back(V(1,0,0,16'h1111,O(0,1,0,0,0,0,0)));
    tbl.push_back(V(1,0,1,16'h1234,O(0,1,0,0,0,0,0)));
    tbl.push_back(V(13,0,0,16'h1234,O(0,1,0,0,0,0,0)));
    tbl.push_back(V(1,0,0,16'h1234,O(0,0,0,3,0,0,0)));
    tbl.push_back(V(1,0,1,16'h1234,O(1,0,0,3,1,0,0)));
    tbl.push_back(V(7,0,0,16'h1234,O(1,0,0,3,0,0,0)));
    tbl.push_back(V(1,0,0,16'h1234,O(0,0,0,3,0,0,0)));
    // Reprogram to 5678; old PIN now fails, new one opens.
    tbl.push_back(V(1,0,1,16'h9999,O(0,0,1,3,0,0,0)));
    tbl.push_back(V(1,0,0,16'h9999,O(0,0,1,3,0,0,0)));
    tbl.push_back(V(1,0,1,16'h5678,O(0,0,0,3,0,0,1)));
    tbl.push_back(V(1,0,0,16'h5678,O(0,0,0,3,0,0,0)));
    tbl.push_back(V(1,0,1,16'h1234,O(0,0,0,2,0,1,0)));
    tbl.push_back(V(1,0,0,16'h1234,O(0,0,0,2,0,0,0)));
    tbl.push_back(V(1,0,1,16'h5678,O(1,0,0,3,1,0,0)));
    tbl.push_back(V(7,0,0,16'h5678,O(1,0,0,3,0,0,0)));
    tbl.push_back(V(1,0,0,16'h5678,O(0,0,0,3,0,0,0)));
    // Reset restores 1234; incomplete PIN in SETUP rejected.
    tbl.push_back(V(1,1,0,16'h0000,O(0,0,0,3,0,0,0)));
    tbl.push_back(V(1,0,1,16'h9999,O(0,0,1,3,0,0,0)));
    tbl.push_back(V(1,0,0,16'h9999,O(0,0,1,3,0,0,0)));
    tbl.push_back(V(1,0,1,16'hAA12,O(0,0,0,3,0,1,0)));
    tbl.push_back(V(1,0,0,16'hAA12,O(0,0,0,3,0,0,0)));
    tbl.push_back(V(1,0,1,16'h1234,O(1,0,0,3,1,0,0)));
    tbl.push_back(V(7,0,0,16'h1234,O(1,0,0,3,0,0,0)));
    tbl.push_back(V(1,0,0,16'h1234,O(0,0,0,3,0,0,0)));
    // SETUP timeout after 12 cycles, no pulse.
    tbl.push_back(V(1,0,1,16'h9999,O(0,0,1,3,0,0,0)));
    tbl.push_back(V(11,0,0,16'h9999,O(0,0,1,3,0,0,0)));
    tbl.push_back(V(1,0,0,16'h9999,O(0,0,0,3,0,0,0)));
    // Submission on the expiry cycle is dropped and not queued.
    tbl.push_back(V(1,0,1,16'h9999,O(0,0,1,3,0,0,0)));
    tbl.push_back(V(11,0,0,16'h9999,O(0,0,1,3,0,0,0)));
    tbl.push_back(V(1,0,1,16'h5678,O(0,0,0,3,0,0,0)));
    tbl.push_back(V(1,0,1,16'h5678,O(0,0,0,3,0,0,0)));
    tbl.push_back(V(1,0,0,16'h5678,O(0,0,0,3,0,0,0)));
    // Incomplete PIN while LOCKED counts as a failure; 5678 must not have stuck.
    tbl.push_back(V(1,0,1,16'h12A4,O(0,0,0,2,0,1,0)));
    tbl.push_back(V(1,0,0,16'h12A4,O(0,0,0,2,0,0,0)));
    tbl.push_back(V(1,0,1,16'h5678,O(0,0,0,1,0,1,0)));
    tbl.push_back(V(1,0,0,16'h5678,O(0,0,0,1,0,0,0)));
    // Status held high 5 cycles -> one pin_ok.
    tbl.push_back(V(1,0,1,16'h1234,O(1,0,0,3,1,0,0)));
    tbl.push_back(V(4,0,1,16'h1234,O(1,0,0,3,0,0,0)));
    tbl.push_back(V(3,0,0,16'h1234,O(1,0,0,3,0,0,0)));
    tbl.push_back(V(1,0,0,16'h1234,O(0,0,0,3,0,0,0)));
    // Open again, reset asserted on the 3rd unlocked cycle.
    tbl.push_back(V(1,0,1,16'h1234,O(1,0,0,3,1,0,0)));
    tbl.push_back(V(2,0,0,16'h1234,O(1,0,0,3,0,0,0)));
    run_tbl("A");

    rst = 1'b1;
    #1 chk("reset mid-unlock", O(0,0,0,3,0,0,0));
    @(posedge clk); #1;
    rst = 1'b0;
    pin_in = '0;

    // Reprogram, reset, and default PIN opens again.
    tbl.push_back(V(1,0,1,16'h9999,O(0,0,1,3,0,0,0)));
    tbl.push_back(V(1,0,0,16'h9999,O(0,0,1,3,0,0,0)));
    tbl.push_back(V(1,0,1,16'h5678,O(0,0,0,3,0,0,1)));
    tbl.push_back(V(1,0,0,16'h5678,O(0,0,0,3,0,0,0)));
    tbl.push_back(V(1,1,0,16'h0000,O(0,0,0,3,0,0,0)));
    tbl.push_back(V(1,0,1,16'h1234,O(1,0,0,3,1,0,0)));
    tbl.push_back(V(7,0,0,16'h1234,O(1,0,0,3,0,0,0)));
    tbl.push_back(V(1,0,0,16'h1234,O(0,0,0,3,0,0,0)));
    run_tbl("C");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/controle_fechadura.md
Name: controle_fechadura

Overview:
Main lock controller for the digital-lock datapath. It consumes the PIN packet produced by the keypad PIN-assembly stage (one-cycle status pulse plus four 4-bit digits) and compares it against the stored user PIN and a fixed admin PIN. It sequences unlock, failed-attempt counting, lockout and user-PIN reprogramming, and drives the lock actuator and status indicators.

Parameters:
DEFAULT_PIN, 16'h1234, user PIN loaded at reset; packed {digit1,digit2,digit3,digit4}.
ADMIN_PIN, 16'h9999, fixed PIN that enters SETUP; never unlocks.
MAX_TRIES, 3, consecutive failures before lockout (>=1).
UNLOCK_CYCLES, 5000, cycles lock_open stays high (>=1).
LOCKOUT_CYCLES, 20000, cycles spent in BLOCKED (>=1).
SETUP_CYCLES, 20000, SETUP timeout in cycles (>=1).

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  asynchronous, active-high reset
pin_in  input  pinPac_t (17)  PIN packet: status, digit1..digit4; digit1 oldest; 4'hA = blank
lock_open  output  1  actuator drive, high only in UNLOCKED
blocked  output  1  high only in BLOCKED
setup_mode  output  1  high only in SETUP
tries_left  output  $clog2(MAX_TRIES+1)  remaining attempts
pin_ok  output  1  one-cycle pulse: user PIN accepted
pin_err  output  1  one-cycle pulse: submission rejected
setup_done  output  1  one-cycle pulse: new user PIN stored

Behaviour:
- Reset (async): state LOCKED, all outputs 0 except tries_left=MAX_TRIES, user PIN register=DEFAULT_PIN, timer=0, status edge register=0. Reset in any state, including mid-UNLOCKED, drops lock_open immediately.
- Submission = rising edge of pin_in.status (internal 1-cycle-delayed copy); status held high counts once. Value P = {digit1,digit2,digit3,digit4} sampled in the edge cycle.
- P incomplete if any digit == 4'hA.
- All pulse and level outputs are registered. Effects appear on the clock edge after the submission cycle (latency 1).
- One shared down-counter timer. On state entry it loads N-1, and the state exits when it reaches 0, so the state lasts exactly N cycles.
- LOCKED:
  - P == ADMIN_PIN -> SETUP; tries_left=MAX_TRIES; no pin_ok/pin_err.
  - P == user PIN (complete) -> UNLOCKED; pin_ok; tries_left=MAX_TRIES.
  - Otherwise, including incomplete P -> pin_err; tries_left-1. If the decrement reaches 0, go to BLOCKED in the same edge.
- UNLOCKED: lock_open=1 for UNLOCK_CYCLES, then LOCKED. Submissions ignored (no pulses).
- BLOCKED: blocked=1 for LOCKOUT_CYCLES, then LOCKED with tries_left=MAX_TRIES. Submissions ignored.
- SETUP: setup_mode=1.
  - Submission with P complete and P != ADMIN_PIN -> store P as user PIN; setup_done; go to LOCKED.
  - Otherwise -> pin_err; user PIN unchanged; go to LOCKED.
  - No submission within SETUP_CYCLES -> LOCKED silently.
  - SETUP failures never touch tries_left.
- Priority in LOCKED: ADMIN_PIN match wins over user match. If DEFAULT_PIN==ADMIN_PIN, the user PIN can only open after reprogramming.
- Submission in the same cycle as a timer expiry: the expiring state's rule applies (ignored). The submission is not queued.
- Only one of pin_ok, pin_err, setup_done may be high in any cycle.
- Illegal state encodings recover to LOCKED.

Test Plan:
- Setup for all scenarios: UNLOCK_CYCLES=8, LOCKOUT_CYCLES=16, SETUP_CYCLES=12.
- Reset -> lock_open=0, blocked=0, setup_mode=0, tries_left=3, all pulses 0.
- Submit 1,2,3,4 (status pulse) -> pin_ok high exactly 1 cycle, 1 cycle after the pulse; lock_open high exactly 8 cycles; a second 1234 during UNLOCKED produces no pulse.
- Submit 1111 three times -> pin_err each time, tries_left 2,1,0, blocked high 16 cycles; 1234 during BLOCKED ignored; afterwards tries_left=3 and 1234 opens.
- Submit 9999 then 5678 -> setup_mode high, then setup_done pulse; then 1234 -> pin_err, tries_left=2; then 5678 -> pin_ok, tries_left=3.
- Submit 9999 then AA12 -> pin_err, user PIN still 1234. Submit 9999, then nothing for 12 cycles -> setup_mode falls with no pulse.
- Status held high 5 cycles with 1234 -> single pin_ok. Assert rst on unlock cycle 3 -> lock_open=0 immediately; after reprogramming to 5678 then reset, 1234 opens again.
